// File: rtl/vga_pkg.sv
// Shared constants and clear-FSM encoding for the VGA frame-memory subsystem.
package vga_pkg;

    localparam int H_START = 100;
    localparam int V_START = 142;
    localparam int IMG_W   = 256;
    localparam int IMG_H   = 256;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 521;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vga_clear_sequencer.sv
// Screen-clear engine: walks every frame address once, writing the latched
// colour only in cycles the display fetch leaves free.
module vga_clear_sequencer
    import vga_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_color,
    input  logic              i_slot_free,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr,
    output logic [2:0]        o_color
);

    clr_state_t        r_state;
    clr_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_color;
    logic              r_done;
    logic              w_write;
    logic              w_last;

    assign w_write = (r_state == CLEAR) && i_slot_free;
    assign w_last  = (r_addr == '1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Requests arriving while already clearing are dropped, never restart.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = CLEAR;
            CLEAR:   if (w_write && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_color <= BLACK;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_write && w_last;
            if ((r_state == IDLE) && i_start) begin
                r_addr  <= '0;
                r_color <= i_color;
            end else if (w_write) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_busy  = (r_state == CLEAR);
    assign o_done  = r_done;
    assign o_addr  = r_addr;
    assign o_color = r_color;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority, then the
// clear engine, then the external pixel writer.
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_START = vga_pkg::H_START,
    parameter int V_START = vga_pkg::V_START,
    parameter int IMG_W   = vga_pkg::IMG_W,
    parameter int IMG_H   = vga_pkg::IMG_H,
    parameter int ADDR_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [9:0]        iHcounter,
    input  logic [9:0]        iVcounter,
    input  logic              iWrReq,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [2:0]        iWrData,
    output logic              oWrAck,
    input  logic              iClearReq,
    input  logic [2:0]        iClearColor,
    output logic              oClearBusy,
    output logic              oClearDone,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic [2:0]        oMemWData,
    input  logic [2:0]        iMemRData,
    output logic [2:0]        oPixelRGB
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [10:0]       w_row;
    logic [10:0]       w_col;
    logic              w_disp;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_clr_busy;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [2:0]        w_clr_color;
    logic              r_vld_p1;
    logic [2:0]        r_pixel;

    // Fetch runs two columns ahead of the beam to cover the RAM read and output register.
    assign w_row       = {1'b0, iVcounter} - 11'(V_START);
    assign w_col       = {1'b0, iHcounter} + 11'd2 - 11'(H_START);
    assign w_disp      = (w_row < 11'(IMG_H)) && (w_col < 11'(IMG_W));
    assign w_disp_addr = ADDR_W'({w_row[ROW_W-1:0], w_col[COL_W-1:0]});

    vga_clear_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .i_clk       (Clock),
        .i_rst_n     (Reset),
        .i_start     (iClearReq),
        .i_color     (iClearColor),
        .i_slot_free (!w_disp),
        .o_busy      (w_clr_busy),
        .o_done      (oClearDone),
        .o_addr      (w_clr_addr),
        .o_color     (w_clr_color)
    );

    assign oClearBusy = w_clr_busy;

    // Outputs are forced idle while reset is held so no stray write reaches the RAM.
    always_comb begin
        oMemAddr  = '0;
        oMemWe    = 1'b0;
        oMemWData = BLACK;
        oWrAck    = 1'b0;
        if (!Reset) begin
            oMemAddr = '0;
        end else if (w_disp) begin
            oMemAddr = w_disp_addr;
        end else if (w_clr_busy) begin
            oMemAddr  = w_clr_addr;
            oMemWe    = 1'b1;
            oMemWData = w_clr_color;
        end else if (iWrReq) begin
            oMemAddr  = iWrAddr;
            oMemWe    = 1'b1;
            oMemWData = iWrData;
            oWrAck    = 1'b1;
        end
    end

    // Stage p1: slot flag waits for the synchronous RAM read; stage p2: output register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_vld_p1 <= 1'b0;
            r_pixel  <= BLACK;
        end else begin
            r_vld_p1 <= w_disp;
            r_pixel  <= r_vld_p1 ? iMemRData : BLACK;
        end
    end

    assign oPixelRGB = r_pixel;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural synchronous-read RAM.
module tb_vga_vram_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [9:0]  iHcounter = '0;
    logic [9:0]  iVcounter = '0;
    logic        iWrReq = 1'b0;
    logic [15:0] iWrAddr = '0;
    logic [2:0]  iWrData = '0;
    logic        oWrAck;
    logic        iClearReq = 1'b0;
    logic [2:0]  iClearColor = '0;
    logic        oClearBusy;
    logic        oClearDone;
    logic [15:0] oMemAddr;
    logic        oMemWe;
    logic [2:0]  oMemWData;
    logic [2:0]  iMemRData;
    logic [2:0]  oPixelRGB;

    logic [2:0]  mem [65536];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [2:0]  bd_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    vga_vram_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iHcounter   (iHcounter),
        .iVcounter   (iVcounter),
        .iWrReq      (iWrReq),
        .iWrAddr     (iWrAddr),
        .iWrData     (iWrData),
        .oWrAck      (oWrAck),
        .iClearReq   (iClearReq),
        .iClearColor (iClearColor),
        .oClearBusy  (oClearBusy),
        .oClearDone  (oClearDone),
        .oMemAddr    (oMemAddr),
        .oMemWe      (oMemWe),
        .oMemWData   (oMemWData),
        .iMemRData   (iMemRData),
        .oPixelRGB   (oPixelRGB)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (oMemWe) mem[oMemAddr] <= oMemWData;
        iMemRData <= mem[oMemAddr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic set_hv(input int h, input int v);
        iHcounter = 10'(h);
        iVcounter = 10'(v);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int exp_addr;
        int k;
        logic slot;

        // Reset state, with inputs that would otherwise produce activity
        @(negedge Clock);
        set_hv(98, 142);
        iWrReq = 1'b1;
        #1;
        check("rst_pixel", oPixelRGB, 3'b000);
        check("rst_we", oMemWe, 1'b0);
        check("rst_addr", oMemAddr, 16'h0000);
        check("rst_ack", oWrAck, 1'b0);
        check("rst_busy", oClearBusy, 1'b0);
        check("rst_done", oClearDone, 1'b0);
        iWrReq = 1'b0;

        bd_we = 1'b1; bd_addr = 16'h0000; bd_data = 3'b101;
        tick();
        bd_addr = 16'h3A34; bd_data = 3'b111;
        tick();
        bd_we = 1'b0;
        Reset = 1'b1;
        set_hv(0, 10);
        tick();

        // Display alignment at the top-left corner
        for (int h = 96; h <= 100; h++) begin
            set_hv(h, 142);
            #1;
            if (h == 98) begin
                check("disp_addr_first", oMemAddr, 16'h0000);
                check("disp_we_first", oMemWe, 1'b0);
            end
            if (h == 99) check("pix_before_window", oPixelRGB, 3'b000);
            if (h == 100) check("pix_first", oPixelRGB, 3'b101);
            tick();
        end
        set_hv(353, 397);
        #1;
        check("disp_addr_last", oMemAddr, 16'hFFFF);
        check("disp_we_last", oMemWe, 1'b0);
        tick();

        // Writer granted immediately in vertical blanking
        set_hv(0, 10);
        iWrReq = 1'b1; iWrAddr = 16'h1234; iWrData = 3'b110;
        #1;
        check("blank_we", oMemWe, 1'b1);
        check("blank_addr", oMemAddr, 16'h1234);
        check("blank_ack", oWrAck, 1'b1);
        check("blank_wdata", oMemWData, 3'b110);
        tick();
        iWrReq = 1'b0;
        #1;
        check("blank_mem", mem[16'h1234], 3'b110);

        // Writer starved through the rest of an active line
        iWrReq = 1'b1; iWrAddr = 16'h0BEE; iWrData = 3'b011;
        errs = 0;
        for (int h = 150; h <= 354; h++) begin
            set_hv(h, 200);
            #1;
            if (h < 354) begin
                if (oWrAck !== 1'b0 || oMemWe !== 1'b0) errs++;
            end else begin
                check("starve_ack_354", oWrAck, 1'b1);
                check("starve_addr_354", oMemAddr, 16'h0BEE);
            end
            tick();
        end
        check("starve_ack_low", errs, 0);
        iWrReq = 1'b0;
        #1;
        check("starve_mem", mem[16'h0BEE], 3'b011);

        // Reset in the middle of a clear
        set_hv(0, 10);
        iClearReq = 1'b1; iClearColor = 3'b001;
        #1;
        tick();
        iClearReq = 1'b0;
        #1;
        check("rclr_busy", oClearBusy, 1'b1);
        tick();
        set_hv(150, 200);
        tick(); tick(); tick();
        check("rclr_pix_before", oPixelRGB, 3'b111);
        Reset = 1'b0;
        #1;
        check("rclr_pix_rst", oPixelRGB, 3'b000);
        check("rclr_we_rst", oMemWe, 1'b0);
        check("rclr_busy_rst", oClearBusy, 1'b0);
        tick(); tick();
        Reset = 1'b1;
        set_hv(0, 10);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (oClearDone !== 1'b0 || oClearBusy !== 1'b0 || oMemWe !== 1'b0) errs++;
            tick();
        end
        check("rclr_no_done", errs, 0);

        // Full clear interleaved with display slots, writer held throughout
        set_hv(0, 0);
        iClearReq = 1'b1; iClearColor = 3'b010;
        #1;
        check("clr_busy_pre", oClearBusy, 1'b0);
        tick();
        iClearReq = 1'b0;
        iWrReq = 1'b1; iWrAddr = 16'h0042; iWrData = 3'b101;
        #1;
        check("clr_busy_start", oClearBusy, 1'b1);
        exp_addr = 0;
        errs = 0;
        k = 0;
        while (exp_addr < 65536 && k < 90000) begin
            slot = (k < 4000) && (k % 4 == 3);
            if (slot) set_hv(150, 200);
            else set_hv(0, 0);
            if (k == 100) begin
                iClearReq = 1'b1; iClearColor = 3'b111;
            end else begin
                iClearReq = 1'b0;
            end
            #1;
            if (slot) begin
                if (oMemWe !== 1'b0 || oWrAck !== 1'b0 || oClearBusy !== 1'b1) errs++;
            end else begin
                if (oMemWe !== 1'b1 || oMemAddr !== 16'(exp_addr) || oMemWData !== 3'b010 ||
                    oWrAck !== 1'b0 || oClearBusy !== 1'b1 || oClearDone !== 1'b0) errs++;
                exp_addr++;
            end
            tick();
            k++;
        end
        check("clr_seq_errs", errs, 0);
        check("clr_count", exp_addr, 65536);
        set_hv(0, 0);
        #1;
        check("clr_done_pulse", oClearDone, 1'b1);
        check("clr_busy_end", oClearBusy, 1'b0);
        check("clr_wr_ack", oWrAck, 1'b1);
        check("clr_wr_addr", oMemAddr, 16'h0042);
        tick();
        iWrReq = 1'b0;
        #1;
        check("clr_done_once", oClearDone, 1'b0);
        check("clr_mem_first", mem[16'h0000], 3'b010);
        check("clr_mem_last", mem[16'hFFFF], 3'b010);
        check("clr_mem_mid", mem[16'h3A34], 3'b010);
        check("clr_mem_writer", mem[16'h0042], 3'b101);

        // Clear request and writer request in the same idle free cycle
        iClearReq = 1'b1; iClearColor = 3'b100;
        iWrReq = 1'b1; iWrAddr = 16'h0777; iWrData = 3'b011;
        #1;
        check("coll_ack", oWrAck, 1'b1);
        check("coll_addr", oMemAddr, 16'h0777);
        check("coll_wdata", oMemWData, 3'b011);
        check("coll_busy_pre", oClearBusy, 1'b0);
        tick();
        iClearReq = 1'b0;
        iWrReq = 1'b0;
        #1;
        check("coll_busy", oClearBusy, 1'b1);
        check("coll_clr_addr", oMemAddr, 16'h0000);
        check("coll_clr_we", oMemWe, 1'b1);
        check("coll_clr_wdata", oMemWData, 3'b100);
        tick();
        check("coll_mem_writer", mem[16'h0777], 3'b011);
        check("coll_mem_clear0", mem[16'h0000], 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
